// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions and the sequencer state encoding.
package alu_issue_ctrl_pkg;

    localparam int NREGS = 4;
    localparam int IW    = 16;

    // Instruction field positions within the 16-bit word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes; the ALU understands the same values zero-extended to 8 bits
    localparam logic [3:0] OP_LDI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_OUT  = 4'b0111;
    localparam logic [3:0] OP_SRAC = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        OUTWAIT = 2'd3
    } state_t;

    // Opcodes that only update carry_flag when they write back
    function automatic logic sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 4 x 8-bit register file: one synchronous write port, two asynchronous
// read ports, cleared by synchronous reset.
module alu_issue_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);

    logic [7:0] regs [NREGS];

    // Reset clears every register; otherwise a single write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction sequencer driving a registered 8-bit ALU. Accepts 16-bit
// instructions, keeps a 4 x 8 register file, issues ALU ops, writes results
// back and emits OUT values over a valid/ready result port.
// Optional build macro: ALU_ISSUE_PERF_CNT_EN adds the retired_cnt counter.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic [7:0]    alu_opcode,
    output logic [7:0]    alu_operand_a,
    output logic [7:0]    alu_operand_b,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          carry_flag,
    output logic          err_unknown,
    output logic          busy
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [15:0]   retired_cnt
`endif
);

    state_t     state;
    logic [3:0] lat_op;
    logic [1:0] lat_rd;

    logic [3:0] op_in;
    logic [1:0] rd_in;
    logic [1:0] rs_in;
    logic [7:0] imm_in;
    logic       transfer;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;

    assign op_in  = instr[OPC_MSB:OPC_LSB];
    assign rd_in  = instr[RD_MSB:RD_LSB];
    assign rs_in  = instr[RS_MSB:RS_LSB];
    assign imm_in = instr[IMM_MSB:IMM_LSB];

    assign instr_ready = (state == IDLE) && !RESET;
    assign transfer    = instr_valid && instr_ready;
    assign busy        = (state != IDLE);

    // Write port: LDI writes on its accept edge, ALU ops write in CAPTURE.
    // The two sources can never coincide because they need different states.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_in;
        rf_wdata = imm_in;
        if (state == IDLE && transfer && op_in == OP_LDI) begin
            rf_we = 1'b1;
        end else if (state == CAPTURE) begin
            rf_we    = 1'b1;
            rf_waddr = lat_rd;
            rf_wdata = alu_result;
        end
    end

    alu_issue_regfile u_regfile (
        .clk     (CLK),
        .reset   (RESET),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rd_in),
        .raddr_b (rs_in),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Sequencer FSM with registered ALU drive, result port and flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            lat_op        <= '0;
            lat_rd        <= '0;
            alu_opcode    <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            carry_flag    <= 1'b0;
            err_unknown   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        case (op_in)
                            OP_LDI: begin
                                state <= IDLE;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRAC: begin
                                lat_op        <= op_in;
                                lat_rd        <= rd_in;
                                alu_opcode    <= {4'b0000, op_in};
                                alu_operand_a <= rdata_a;
                                alu_operand_b <= rdata_b;
                                state         <= ISSUE;
                            end
                            OP_OUT: begin
                                out_data  <= rdata_a;
                                out_valid <= 1'b1;
                                state     <= OUTWAIT;
                            end
                            default: begin
                                err_unknown <= 1'b1;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    alu_opcode <= '0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    if (sets_carry(lat_op)) begin
                        carry_flag <= alu_carry;
                    end
                    state <= IDLE;
                end
                OUTWAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic retire;

    assign retire = (state == IDLE && transfer && op_in == OP_LDI)
                 || (state == CAPTURE)
                 || (state == OUTWAIT && out_ready);

    // Count completed instructions; wraps naturally at 16 bits
    always_ff @(posedge CLK) begin
        if (RESET) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard testbench for alu_issue_ctrl: directed scenarios followed by
// random instruction streams, with an external registered ALU model.
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [7:0]  alu_opcode;
    logic [7:0]  alu_operand_a;
    logic [7:0]  alu_operand_b;
    logic [7:0]  alu_result = '0;
    logic        alu_carry = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        carry_flag;
    logic        err_unknown;
    logic        busy;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    alu_issue_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_opcode    (alu_opcode),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .carry_flag    (carry_flag),
        .err_unknown   (err_unknown),
        .busy          (busy)
`ifdef ALU_ISSUE_PERF_CNT_EN
        ,
        .retired_cnt   (retired_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int pass_count = 0;
    int check_count = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Registered ALU sitting on the other side of the controller
    always @(posedge CLK) begin
        case (alu_opcode)
            8'h02: {alu_carry, alu_result} <= {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
            8'h03: begin
                alu_result <= alu_operand_a - alu_operand_b;
                alu_carry  <= (alu_operand_a < alu_operand_b);
            end
            8'h04: alu_result <= alu_operand_a & alu_operand_b;
            8'h05: alu_result <= alu_operand_a | alu_operand_b;
            8'h06: alu_result <= alu_operand_a ^ alu_operand_b;
            8'h08: alu_result <= alu_operand_a >> alu_operand_b;
            default: ;
        endcase
    end

    // Reference model: architectural register state and expected outputs
    typedef struct {
        logic [7:0]  data;
        logic        carry;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic [7:0]  m_regs [4];
    logic        m_carry = 1'b0;
    logic        m_err = 1'b0;
    int unsigned m_cnt = 0;
    exp_t        exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_carry = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    task automatic model_exec(input logic [15:0] w);
        int op;
        int rd;
        int a;
        int b;
        int r;
        exp_t e;
        op = int'(w[15:12]);
        rd = int'(w[11:10]);
        a  = int'(m_regs[w[11:10]]);
        b  = int'(m_regs[w[9:8]]);
        r  = a;
        case (op)
            1: begin m_regs[rd] = w[7:0]; m_cnt++; end
            2: begin r = a + b; m_carry = (r > 255); m_regs[rd] = 8'(r % 256); m_cnt++; end
            3: begin m_carry = (a < b); m_regs[rd] = 8'((a - b + 256) % 256); m_cnt++; end
            4: begin m_regs[rd] = 8'(a) & 8'(b); m_cnt++; end
            5: begin m_regs[rd] = 8'(a) | 8'(b); m_cnt++; end
            6: begin m_regs[rd] = 8'(a) ^ 8'(b); m_cnt++; end
            8: begin m_regs[rd] = (b >= 8) ? 8'h00 : 8'(a / (1 << b)); m_cnt++; end
            7: begin
                e.data  = 8'(a);
                e.carry = m_carry;
                e.err   = m_err;
                e.cnt   = 16'(m_cnt);
                exp_q.push_back(e);
                m_cnt++;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    // Offer one instruction and wait (bounded) for it to be accepted
    task automatic applyStimulus(input logic [15:0] w);
        int waited = 0;
        @(negedge CLK);
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("accept_timeout", {15'd0, instr_ready}, 16'd1);
            instr_valid = 1'b0;
        end else begin
            model_exec(w);
            @(posedge CLK);
            #1;
            instr_valid = 1'b0;
        end
    endtask

    // Result-port backpressure: random or forced-low windows
    int  hold_token = 0;
    bit  random_ready = 1'b0;
    int  hold_seen = 0;
    int  hold_left = 0;

    always @(posedge CLK) begin
        #2;
        if (hold_token != hold_seen) begin
            hold_seen = hold_token;
            hold_left = 6;
        end
        if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else begin
            out_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every result handshake
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid) checkOutput("no_accept_while_out", {15'd0, instr_ready}, 16'd0);
            if (prev_stall) begin
                checkOutput("out_valid_held", {15'd0, out_valid}, 16'd1);
                checkOutput("out_data_stable", {8'd0, out_data}, {8'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("out_unexpected", 16'(exp_q.size()), 16'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_data", {8'd0, out_data}, {8'd0, e.data});
                    checkOutput("out_carry_flag", {15'd0, carry_flag}, {15'd0, e.carry});
                    checkOutput("out_err_unknown", {15'd0, err_unknown}, {15'd0, e.err});
`ifdef ALU_ISSUE_PERF_CNT_EN
                    checkOutput("retired_cnt", retired_cnt, e.cnt);
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, "_out_data"}, {8'd0, out_data}, 16'd0);
        checkOutput({tag, "_carry"}, {15'd0, carry_flag}, 16'd0);
        checkOutput({tag, "_err"}, {15'd0, err_unknown}, 16'd0);
        checkOutput({tag, "_alu_opcode"}, {8'd0, alu_opcode}, 16'd0);
        checkOutput({tag, "_alu_a"}, {8'd0, alu_operand_a}, 16'd0);
        checkOutput({tag, "_alu_b"}, {8'd0, alu_operand_b}, 16'd0);
        checkOutput({tag, "_instr_ready"}, {15'd0, instr_ready}, 16'd1);
    endtask

    initial begin
        logic [3:0]  legal_ops [7];
        logic [3:0]  op;
        logic [15:0] w;
        int          n;

        legal_ops[0] = 4'h1; legal_ops[1] = 4'h2; legal_ops[2] = 4'h3;
        legal_ops[3] = 4'h4; legal_ops[4] = 4'h5; legal_ops[5] = 4'h6;
        legal_ops[6] = 4'h8;

        model_reset();
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("por");

        // Reset in the middle of an ALU operation
        applyStimulus(16'h1055);
        applyStimulus(16'h2000);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("rst_instr_ready_low", {15'd0, instr_ready}, 16'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        check_reset_state("mid_issue");
        applyStimulus(16'h7000);

        // ADD with carry and issue timing
        applyStimulus(16'h10F0);
        applyStimulus(16'h1420);
        applyStimulus(16'h2100);
        @(negedge CLK);
        checkOutput("add_ready_low_1", {15'd0, instr_ready}, 16'd0);
        checkOutput("add_busy", {15'd0, busy}, 16'd1);
        checkOutput("add_alu_opcode", {8'd0, alu_opcode}, 16'h0002);
        checkOutput("add_alu_a", {8'd0, alu_operand_a}, 16'h00F0);
        checkOutput("add_alu_b", {8'd0, alu_operand_b}, 16'h0020);
        @(negedge CLK);
        checkOutput("add_ready_low_2", {15'd0, instr_ready}, 16'd0);
        checkOutput("add_opcode_cleared", {8'd0, alu_opcode}, 16'd0);
        @(negedge CLK);
        checkOutput("add_ready_back", {15'd0, instr_ready}, 16'd1);
        checkOutput("add_carry_flag", {15'd0, carry_flag}, 16'd1);
        applyStimulus(16'h7000);

        // SUB with borrow, then AND keeps the carry flag
        applyStimulus(16'h1805);
        applyStimulus(16'h1C07);
        applyStimulus(16'h3B00);
        applyStimulus(16'h4B00);
        @(negedge CLK);
        checkOutput("and_keeps_carry", {15'd0, carry_flag}, 16'd1);

        // OUT under backpressure
        hold_token++;
        applyStimulus(16'h7800);
        repeat (4) begin
            @(negedge CLK);
            checkOutput("bp_out_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("bp_out_data", {8'd0, out_data}, 16'h0006);
            checkOutput("bp_instr_blocked", {15'd0, instr_ready}, 16'd0);
        end

        // Illegal opcode then shift
        applyStimulus(16'hF000);
        @(negedge CLK);
        checkOutput("err_set", {15'd0, err_unknown}, 16'd1);
        applyStimulus(16'h7C00);
        applyStimulus(16'h1480);
        applyStimulus(16'h1003);
        applyStimulus(16'h8400);
        applyStimulus(16'h7400);
        @(negedge CLK);
        checkOutput("err_sticky", {15'd0, err_unknown}, 16'd1);

        // Random instruction stream with random backpressure
        random_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 19));
            if (n == 0) op = 4'($urandom_range(0, 15));
            else if (n < 5) op = 4'h7;
            else op = legal_ops[$urandom_range(0, 6)];
            w = {op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            if (op == 4'h8 && $urandom_range(0, 1) == 1) w[7:0] = 8'h00;
            applyStimulus(w);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        @(negedge CLK);
        checkOutput("final_err", {15'd0, err_unknown}, {15'd0, m_err});
        checkOutput("final_carry", {15'd0, carry_flag}, {15'd0, m_carry});
`ifdef ALU_ISSUE_PERF_CNT_EN
        checkOutput("final_retired_cnt", retired_cnt, 16'(m_cnt));
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
